// File: rtl/gf2_polydiv.sv
// Iterative GF(2) polynomial long divider: one quotient bit per clock, D = Q*V xor R.
// Valid/ready on both sides; a zero divisor short-circuits to DONE with div_zero set.
module gf2_polydiv #(
    parameter int unsigned DW = 31,
    parameter int unsigned VW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] quotient_o,
    output logic [VW-2:0] remainder_o,
    output logic          div_zero_o
);

    localparam int unsigned KW  = $clog2(DW);
    localparam int unsigned DVW = $clog2(VW);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            div_zero_q;
    logic [DW-1:0]   quot_q;
    logic [VW-2:0]   rem_q;
    logic [DW-1:0]   dvd_q;
    logic [VW-1:0]   dvs_q;
    logic [DVW-1:0]  dv_q;
    logic [KW-1:0]   k_q;
    logic [VW-2:0]   p_q;
    logic [DW-1:0]   qw_q;

    logic [DVW-1:0]  dv_d;
    logic [VW-1:0]   p_shift;
    logic [VW-1:0]   p_full;
    logic            hit;
    logic            unused_p_msb;

    // Degree of the incoming divisor (highest set bit wins).
    always_comb begin
        dv_d = '0;
        for (int i = 0; i < int'(VW); i++) begin
            if (divisor_i[i]) begin
                dv_d = DVW'(i);
            end
        end
    end

    // The stored P is one bit narrower than V: bit dv is always cleared by the xor.
    always_comb begin
        p_shift = {p_q, dvd_q[k_q]};
        hit     = p_shift[dv_q];
        p_full  = hit ? (p_shift ^ dvs_q) : p_shift;
    end

    assign unused_p_msb = p_full[VW-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            div_zero_q  <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            dv_q        <= '0;
            k_q         <= '0;
            p_q         <= '0;
            qw_q        <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i && in_ready_q) begin
                        dvd_q      <= dividend_i;
                        dvs_q      <= divisor_i;
                        dv_q       <= dv_d;
                        p_q        <= '0;
                        qw_q       <= '0;
                        k_q        <= KW'(DW - 1);
                        in_ready_q <= 1'b0;
                        div_zero_q <= 1'b0;
                        if (divisor_i == '0) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                            div_zero_q  <= 1'b1;
                            quot_q      <= '0;
                            rem_q       <= '0;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    p_q       <= p_full[VW-2:0];
                    qw_q[k_q] <= hit;
                    k_q       <= k_q - 1'b1;
                    if (k_q == '0) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        quot_q      <= {qw_q[DW-1:1], hit};
                        rem_q       <= p_full[VW-2:0];
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rem_q;
    assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_gf2_polydiv.sv
// Bench for gf2_polydiv: directed and random divides checked against a degree-based
// long-division model, with a per-cycle output monitor.
module tb_gf2_polydiv;

    localparam int unsigned DW = 31;
    localparam int unsigned VW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-2:0] remainder;
    logic          div_zero;

    int            vectors;
    int            miscompares;
    logic          mon_en;
    logic [DW-1:0] exp_q;
    logic [VW-2:0] exp_r;
    logic          exp_z;

    gf2_polydiv #(.DW(DW), .VW(VW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder),
        .div_zero_o  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int deg(input logic [VW-1:0] v);
        int d = -1;
        for (int i = 0; i < int'(VW); i++) if (v[i]) d = i;
        return d;
    endfunction

    // Schoolbook division by degree: cancel the leading term with a shifted copy of V.
    task automatic model(input logic [DW-1:0] d, input logic [VW-1:0] v,
                         output logic [DW-1:0] q, output logic [VW-2:0] r, output logic z);
        logic [DW-1:0] rem;
        int dv;
        q = '0;
        r = '0;
        z = (v == '0);
        if (!z) begin
            dv  = deg(v);
            rem = d;
            for (int i = int'(DW) - 1; i >= dv; i--) begin
                if (rem[i]) begin
                    rem ^= DW'(v) << (i - dv);
                    q[i - dv] = 1'b1;
                end
            end
            r = rem[VW-2:0];
        end
    endtask

    function automatic logic [DW-1:0] clmul(input logic [DW-1:0] a, input logic [VW-1:0] b);
        logic [DW-1:0] p = '0;
        for (int i = 0; i < int'(VW); i++) if (b[i]) p ^= a << i;
        return p;
    endfunction

    task automatic run(input logic [DW-1:0] d, input logic [VW-1:0] v,
                       input logic [DW-1:0] eq, input logic [VW-2:0] er, input logic ez,
                       input int hold);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        dividend = d;
        divisor  = v;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q  = eq;
        exp_r  = er;
        exp_z  = ez;
        mon_en = 1'b1;
        #1;
        in_valid = 1'b0;
        dividend = ~d;
        divisor  = ~v;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid === 1'b1) break;
        end
        chk("latency", n, ez ? 32'd1 : 32'd32);
        if (hold > 0) begin
            in_valid = 1'b1;
            dividend = 31'h0000_1234;
            divisor  = 16'h0007;
            repeat (hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Pins the model to a hand-computed answer, then runs the DUT against it.
    task automatic lit(input logic [DW-1:0] d, input logic [VW-1:0] v,
                       input logic [DW-1:0] q, input logic [VW-2:0] r, input int hold);
        logic [DW-1:0] mq;
        logic [VW-2:0] mr;
        logic          mz;
        model(d, v, mq, mr, mz);
        chk("model_q", 32'(mq), 32'(q));
        chk("model_r", 32'(mr), 32'(r));
        run(d, v, mq, mr, mz, hold);
    endtask

    initial begin
        logic [DW-1:0] a, d, mq;
        logic [VW-1:0] b;
        logic [VW-2:0] r0, mr;
        logic          mz;
        int db, hold;
        vectors = 0;
        miscompares = 0;
        mon_en = 1'b0;
        exp_q = '0;
        exp_r = '0;
        exp_z = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;

        fork
            forever begin
                @(negedge clk);
                if (mon_en && out_valid === 1'b1) begin
                    chk("mon_quotient", 32'(quotient), 32'(exp_q));
                    chk("mon_remainder", 32'(remainder), 32'(exp_r));
                    chk("mon_div_zero", {31'd0, div_zero}, {31'd0, exp_z});
                    chk("mon_in_ready", {31'd0, in_ready}, 32'd0);
                end
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        rst = 1'b0;

        lit(31'h0000_0005, 16'h0003, 31'h0000_0003, 15'h0000, 0);
        lit(31'h0000_0007, 16'h0003, 31'h0000_0002, 15'h0001, 0);
        lit(31'h4000_8000, 16'h8000, 31'h0000_8001, 15'h0000, 0);
        lit(31'h7FFF_FFFF, 16'h0001, 31'h7FFF_FFFF, 15'h0000, 0);
        lit(31'h0000_001F, 16'h0100, 31'h0000_0000, 15'h001F, 0);
        lit(31'h0000_7FFF, 16'h8001, 31'h0000_0000, 15'h7FFF, 0);
        lit(31'h0000_0000, 16'h1234, 31'h0000_0000, 15'h0000, 0);

        run(31'h1234_5678, 16'h0000, 31'h0, 15'h0, 1'b1, 0);
        lit(31'h0000_0007, 16'h0003, 31'h0000_0002, 15'h0001, 0);
        lit(31'h0000_0005, 16'h0003, 31'h0000_0003, 15'h0000, 5);

        // Reset mid-CALC discards the operation and clears the outputs.
        @(negedge clk);
        in_valid = 1'b1;
        dividend = 31'h0ABC_DEF1;
        divisor  = 16'h0103;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mon_en = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        lit(31'h0000_0007, 16'h0003, 31'h0000_0002, 15'h0001, 0);

        for (int i = 0; i < 1000; i++) begin
            b = VW'($urandom);
            if (b == '0) b = 16'h0001;
            db = deg(b);
            a  = DW'($urandom) & DW'((64'd1 << (int'(DW) - db)) - 64'd1);
            r0 = (VW-1)'($urandom) & (VW-1)'((32'd1 << db) - 32'd1);
            d  = clmul(a, b) ^ DW'(r0);
            model(d, b, mq, mr, mz);
            if (i % 50 == 0) begin
                chk("model_rand_q", 32'(mq), 32'(a));
                chk("model_rand_r", 32'(mr), 32'(r0));
            end
            hold = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            run(d, b, a, r0, 1'b0, hold);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gf2_polydiv.md
Name: gf2_polydiv

Overview:
- Iterative GF(2) polynomial long divider. It is the inverse of the Karatsuba GF(2) multiplier datapath.
- Takes a 31-bit carry-less dividend, such as a 16x16 product, and a 16-bit divisor. Returns quotient and remainder, one quotient bit per clock.
- Serves the authenticated-encryption core for product reduction and for checking multiplier results.
- Valid/ready handshake on both input and output.

Parameters:
- DW, 31, dividend width (bit i = coefficient of x^i). Quotient is also DW bits.
- VW, 16, divisor width. Remainder is VW-1 bits. Constraint: DW >= VW >= 2.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operands present
- in_ready  out  1  divider idle and able to accept
- dividend  in  DW  dividend polynomial D
- divisor  in  VW  divisor polynomial V
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- quotient  out  DW  Q, where D = Q·V xor R (carry-less)
- remainder  out  VW-1  R, with deg(R) < deg(V)
- div_zero  out  1  V was zero; Q and R forced to 0

Behaviour:
- Reset: synchronous, active-high, one clock, and overrides everything (including mid-CALC). State goes to IDLE. Outputs reset to in_ready=1, out_valid=0, quotient=0, remainder=0, div_zero=0. Any in-flight operation is discarded.
- FSM: IDLE -> CALC -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch D and V.
  - Compute dv = index of the highest set bit of V (priority encoder).
  - Clear the partial remainder P (VW bits) and the iteration counter k=DW-1.
  - If V==0: go to DONE with div_zero=1, Q=0, R=0.
  - Else: go to CALC.
- CALC: one step per cycle, k = DW-1 down to 0.
  - Form P' = (P<<1) | D[k].
  - If P'[dv]==1: P = P' xor V and Q[k]=1. Else: P = P' and Q[k]=0.
  - P never exceeds degree dv after a step; bits above dv remain 0.
  - After the k=0 step, go to DONE.
  - CALC lasts exactly DW cycles, independent of dv.
- DONE:
  - out_valid=1.
  - quotient, remainder (= P[VW-2:0]) and div_zero are stable and held while out_ready=0.
  - On out_valid&out_ready: go to IDLE and drop out_valid.
- Latency (handshake cycle = t):
  - Nonzero V: out_valid at t+DW+1, i.e. t+32.
  - V==0: out_valid at t+1.
- No overlap: in_ready=0 throughout CALC and DONE. A new input is accepted no earlier than the cycle after output handshake.
- Outputs hold their last values in IDLE. div_zero is cleared on the next accept.
- in_valid during CALC/DONE is ignored; the upstream holds it.
- dividend/divisor are sampled only on the accept cycle. Later changes have no effect.
- Boundary cases:
  - V=1 (dv=0): Q=D, R=0.
  - V with dv=VW-1: full-width remainder.
  - D=0: Q=0, R=0, full latency.
  - deg(D) < dv: Q=0, R=D.
- Arithmetic is xor only; no carries anywhere.

Test Plan:
- D=0x00000005 (x^2+1), V=0x0003 -> Q=0x00000003, R=0x0000, div_zero=0. out_valid exactly 32 cycles after accept.
- D=0x00000007, V=0x0003 -> Q=0x00000002, R=0x0001.
- D=0x40008000, V=0x8000 -> Q=0x00008001, R=0x0000. D=0x7FFFFFFF, V=0x0001 -> Q=0x7FFFFFFF, R=0. D=0x0000001F, V=0x0100 -> Q=0, R=0x001F.
- V=0x0000, D=0x12345678 -> out_valid 1 cycle after accept, div_zero=1, Q=0, R=0. After the next nonzero divide, div_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, Q and R stable, in_ready=0. New in_valid is held and not accepted until the cycle after the out_ready handshake.
- Reset: assert rst during CALC, 10 cycles after accept -> next cycle in_ready=1, out_valid=0, Q=R=0. A new divide then completes correctly.
- Random: 1000 random (A,B,R0) with deg(R0) < deg(B). Feed D = A·B xor R0 using a carry-less reference model -> Q=A, R=R0.
